// File: rtl/wm_cfg_sequencer_if.sv
// WM8731 configuration sequencer <-> I2C byte-pair writer handshake.
// The sequencer is the master: it pulses i2c_go with a stable i2c_word and
// the writer answers with a single-cycle i2c_done, qualified by i2c_nack.
interface wm_cfg_sequencer_if;
   logic        i2c_go;
   logic [15:0] i2c_word;
   logic        i2c_done;
   logic        i2c_nack;

   modport master (
      output i2c_go,
      output i2c_word,
      input  i2c_done,
      input  i2c_nack
   );

   modport slave (
      input  i2c_go,
      input  i2c_word,
      output i2c_done,
      output i2c_nack
   );
endinterface

// File: rtl/wm_cfg_sequencer.sv
// WM8731 configuration sequencer.
// Walks the codec power-up init table and services headphone-volume updates
// through one shared I2C writer, with NACK retry, an inter-write gap and a
// sticky error flag. Init has fixed priority; a volume request is parked in
// vol_pend until the sequencer is idle with no cfg_go in the same cycle.
//
// Optional feature: define CFG_TIMEOUT_EN to add a watchdog on i2c_done.
// A write that sees no i2c_done within TIMEOUT_CYCLES is treated as a NACK.
// Without the macro WAIT waits indefinitely and no watchdog logic exists.
//
// state  | meaning
// IDLE   | nothing in flight; accepts cfg_go, else services vol_pend
// LOAD   | latch the next word (ROM entry or volume word), clear retry count
// ISSUE  | one-cycle i2c_go to the writer
// WAIT   | waiting for i2c_done (and the watchdog when enabled)
// GAP    | bus idle time before the next write, retry or return to IDLE
module wm_cfg_sequencer #(
   parameter int GAP_CYCLES     = 500,
   parameter int MAX_RETRY      = 3,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                      clk_50m,
   input  logic                      rst_n,
   input  logic                      cfg_go,
   output logic                      cfg_done,
   output logic                      cfg_err,
   input  logic                      vol_req,
   input  logic [6:0]                vol_val,
   output logic                      vol_ack,
   output logic                      busy,
   wm_cfg_sequencer_if.master        i2c
);

   localparam int         GAP_W    = $clog2(GAP_CYCLES + 1);
   localparam int         RETRY_W  = $clog2(MAX_RETRY + 1);
   localparam logic [3:0] LAST_IDX = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t               state;
   state_t               state_nxt;

   logic                 src_vol;
   logic [3:0]           idx;
   logic [RETRY_W-1:0]   retry;
   logic                 retry_pend;
   logic                 vol_pend;
   logic [6:0]           vol_reg;
   logic [GAP_W-1:0]     gap_cnt;
   logic [15:0]          word_reg;

   logic                 wait_ok;
   logic                 wait_fail;
   logic                 can_retry;
   logic                 gap_end;
   logic                 tmo_hit;

   // Power-up register image, written in this order.
   function automatic logic [15:0] rom_word(input logic [3:0] i);
      logic [15:0] w;
      case (i)
         4'd0:    w = 16'h1E00;
         4'd1:    w = 16'h0C00;
         4'd2:    w = 16'h0017;
         4'd3:    w = 16'h0217;
         4'd4:    w = 16'h0479;
         4'd5:    w = 16'h0679;
         4'd6:    w = 16'h0812;
         4'd7:    w = 16'h0A00;
         4'd8:    w = 16'h0E42;
         4'd9:    w = 16'h1000;
         4'd10:   w = 16'h1201;
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

`ifdef CFG_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt;

   // Watchdog down-counter: armed in ISSUE, runs down through WAIT.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (state == S_ISSUE) begin
         tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
      end else if (state == S_WAIT && tmo_cnt != '0) begin
         tmo_cnt <= tmo_cnt - TMO_W'(1);
      end
   end

   assign tmo_hit = (state == S_WAIT) && !i2c.i2c_done && (tmo_cnt == '0);
`else
   logic unused_tmo_cfg;

   assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
   assign tmo_hit        = 1'b0;
`endif

   // Outcome of the transaction in flight; a watchdog expiry counts as NACK.
   always_comb begin
      wait_ok   = (state == S_WAIT) && i2c.i2c_done && !i2c.i2c_nack;
      wait_fail = (state == S_WAIT) && ((i2c.i2c_done && i2c.i2c_nack) || tmo_hit);
      can_retry = (retry < RETRY_W'(MAX_RETRY));
      gap_end   = (gap_cnt == '0);
   end

   // State register.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cfg_go || vol_pend) begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD:  state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (wait_ok) begin
               state_nxt = S_GAP;
            end else if (wait_fail) begin
               state_nxt = can_retry ? S_GAP : S_IDLE;
            end
         end
         S_GAP: begin
            if (gap_end) begin
               if (retry_pend) begin
                  state_nxt = S_ISSUE;
               end else if (!src_vol && !cfg_done) begin
                  state_nxt = S_LOAD;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Moore outputs.
   always_comb begin
      busy       = (state != S_IDLE);
      i2c.i2c_go = (state == S_ISSUE);
   end

   assign i2c.i2c_word = word_reg;

   // Pending volume request: the last requested value wins until it is loaded.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         vol_pend <= 1'b0;
         vol_reg  <= 7'h00;
      end else begin
         if (state == S_LOAD && src_vol) begin
            vol_pend <= 1'b0;
         end
         if (vol_req) begin
            vol_pend <= 1'b1;
            vol_reg  <= vol_val;
         end
      end
   end

   // Write bookkeeping: source, table index, retries, gap timer, status flags.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         src_vol    <= 1'b0;
         idx        <= 4'd0;
         retry      <= '0;
         retry_pend <= 1'b0;
         gap_cnt    <= '0;
         word_reg   <= 16'h0000;
         cfg_done   <= 1'b0;
         cfg_err    <= 1'b0;
         vol_ack    <= 1'b0;
      end else begin
         vol_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cfg_go) begin
                  src_vol  <= 1'b0;
                  idx      <= 4'd0;
                  cfg_done <= 1'b0;
                  cfg_err  <= 1'b0;
               end else if (vol_pend) begin
                  src_vol <= 1'b1;
               end
            end
            S_LOAD: begin
               word_reg   <= src_vol ? {7'h02, 2'b11, vol_reg} : rom_word(idx);
               retry      <= '0;
               retry_pend <= 1'b0;
            end
            S_ISSUE: begin
               retry_pend <= 1'b0;
            end
            S_WAIT: begin
               if (wait_ok) begin
                  gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                  if (src_vol) begin
                     vol_ack <= 1'b1;
                  end else if (idx == LAST_IDX) begin
                     cfg_done <= 1'b1;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end else if (wait_fail) begin
                  if (can_retry) begin
                     retry      <= retry + RETRY_W'(1);
                     retry_pend <= 1'b1;
                     gap_cnt    <= GAP_W'(GAP_CYCLES - 1);
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            S_GAP: begin
               if (!gap_end) begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               retry_pend <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wm_cfg_sequencer.sv
// Directed bench for wm_cfg_sequencer with a behavioural I2C writer that
// answers 100 cycles after each i2c_go and can be told to NACK or go silent.
module tb_wm_cfg_sequencer;

   logic       clk_50m = 1'b0;
   logic       rst_n   = 1'b0;
   logic       cfg_go  = 1'b0;
   logic       vol_req = 1'b0;
   logic [6:0] vol_val = 7'h00;
   logic       cfg_done;
   logic       cfg_err;
   logic       vol_ack;
   logic       busy;

   wm_cfg_sequencer_if ifc ();

   wm_cfg_sequencer #(.TIMEOUT_CYCLES(1000)) dut (
      .clk_50m  (clk_50m),
      .rst_n    (rst_n),
      .cfg_go   (cfg_go),
      .cfg_done (cfg_done),
      .cfg_err  (cfg_err),
      .vol_req  (vol_req),
      .vol_val  (vol_val),
      .vol_ack  (vol_ack),
      .busy     (busy),
      .i2c      (ifc)
   );

   always #10 clk_50m = ~clk_50m;

   int cyc = 0;
   always @(posedge clk_50m) cyc <= cyc + 1;

   logic [15:0] exp_rom [0:10] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479,
                                   16'h0679, 16'h0812, 16'h0A00, 16'h0E42, 16'h1000,
                                   16'h1201};

   logic [15:0] log_word [0:127];
   int          log_cyc  [0:127];
   int          log_n  = 0;
   int          vack_n = 0;

   int          n_chk  = 0;
   int          n_fail = 0;

   logic [15:0] nack_word = 16'h0000;
   int          nack_left = 0;
   logic        no_resp   = 1'b0;

   // Monitor: log every i2c_go word and count vol_ack pulses.
   always @(negedge clk_50m) begin
      if (ifc.i2c_go) begin
         if (log_n < 128) begin
            log_word[log_n] = ifc.i2c_word;
            log_cyc[log_n]  = cyc;
         end
         log_n++;
      end
      if (vol_ack) vack_n++;
   end

   // Writer model.
   initial begin
      logic [15:0] w;
      logic        abort;
      ifc.i2c_done = 1'b0;
      ifc.i2c_nack = 1'b0;
      forever begin
         @(negedge clk_50m);
         if (ifc.i2c_go && rst_n && !no_resp) begin
            w     = ifc.i2c_word;
            abort = 1'b0;
            for (int k = 0; k < 100; k++) begin
               @(negedge clk_50m);
               if (!rst_n) abort = 1'b1;
            end
            if (!abort) begin
               ifc.i2c_nack = 1'b0;
               if (w == nack_word && nack_left != 0) begin
                  ifc.i2c_nack = 1'b1;
                  if (nack_left > 0) nack_left--;
               end
               ifc.i2c_done = 1'b1;
               @(negedge clk_50m);
               ifc.i2c_done = 1'b0;
               ifc.i2c_nack = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_go(output int go_cyc);
      @(negedge clk_50m);
      cfg_go = 1'b1;
      go_cyc = cyc;
      @(negedge clk_50m);
      cfg_go = 1'b0;
   endtask

   task automatic wait_for(input int exp_log, input int budget, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk_50m);
         #2;
         n++;
      end while ((busy || log_n < exp_log) && n < budget);
      chk({tag, "_settled"}, {31'd0, busy || (log_n < exp_log)}, 32'd0);
   endtask

   task automatic wait_log(input int exp_log, input int budget);
      int n;
      n = 0;
      while (log_n < exp_log && n < budget) begin
         @(negedge clk_50m);
         #2;
         n++;
      end
      chk("log_reached", {31'd0, log_n >= exp_log}, 32'd1);
   endtask

   function automatic int count_word(input int from, input int to, input logic [15:0] w);
      int c;
      c = 0;
      for (int i = from; i < to && i < 128; i++) if (log_word[i] == w) c++;
      return c;
   endfunction

   function automatic int min_gap(input int from, input int to);
      int m;
      m = 32'h7fffffff;
      for (int i = from + 1; i < to && i < 128; i++)
         if (log_cyc[i] - log_cyc[i-1] < m) m = log_cyc[i] - log_cyc[i-1];
      return m;
   endfunction

   initial begin
      int base;
      int g0;
      int ok;

      // Reset values
      repeat (3) @(negedge clk_50m);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_50m);
      #2;
      chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
      chk("rst_cfg_err",  {31'd0, cfg_err},  32'd0);
      chk("rst_vol_ack",  {31'd0, vol_ack},  32'd0);
      chk("rst_busy",     {31'd0, busy},     32'd0);
      chk("rst_i2c_go",   {31'd0, ifc.i2c_go}, 32'd0);
      chk("rst_i2c_word", {16'd0, ifc.i2c_word}, 32'h0000);

      // Full init walk, all ACKed
      base = log_n;
      pulse_go(g0);
      wait_for(base + 11, 15000, "walk");
      chk("walk_count", log_n - base, 11);
      ok = 1;
      for (int i = 0; i < 11; i++) if (log_word[base + i] != exp_rom[i]) ok = 0;
      chk("walk_words_in_order", ok, 1);
      chk("walk_word0", {16'd0, log_word[base]}, 32'h1E00);
      chk("walk_word10", {16'd0, log_word[base + 10]}, 32'h1201);
      chk("walk_latency", log_cyc[base] - g0, 2);
      chk("walk_spacing_ge_500", {31'd0, min_gap(base, base + 11) >= 500}, 32'd1);
      chk("walk_cfg_done", {31'd0, cfg_done}, 32'd1);
      chk("walk_cfg_err",  {31'd0, cfg_err},  32'd0);
      chk("walk_busy",     {31'd0, busy},     32'd0);
      chk("walk_no_vol_ack", vack_n, 0);

      // NACK index 4 twice, then ACK
      nack_word = 16'h0479;
      nack_left = 2;
      base = log_n;
      pulse_go(g0);
      wait_for(base + 13, 20000, "nack2");
      chk("nack2_count", log_n - base, 13);
      chk("nack2_0479_issues", count_word(base, base + 13, 16'h0479), 3);
      chk("nack2_last_word", {16'd0, log_word[base + 12]}, 32'h1201);
      chk("nack2_cfg_done", {31'd0, cfg_done}, 32'd1);
      chk("nack2_cfg_err",  {31'd0, cfg_err},  32'd0);

      // Index 2 always NACKs
      nack_word = 16'h0017;
      nack_left = -1;
      base = log_n;
      pulse_go(g0);
      wait_for(base + 6, 20000, "nackall");
      repeat (2000) @(negedge clk_50m);
      #2;
      chk("nackall_count", log_n - base, 6);
      chk("nackall_0017_issues", count_word(base, base + 6, 16'h0017), 4);
      chk("nackall_cfg_err",  {31'd0, cfg_err},  32'd1);
      chk("nackall_cfg_done", {31'd0, cfg_done}, 32'd0);
      chk("nackall_busy",     {31'd0, busy},     32'd0);
      nack_left = 0;

      // Volume requests during the walk; last value wins
      base = log_n;
      pulse_go(g0);
      #2;
      chk("vol_err_cleared", {31'd0, cfg_err}, 32'd0);
      repeat (50) @(negedge clk_50m);
      vol_req = 1'b1;
      vol_val = 7'h79;
      @(negedge clk_50m);
      vol_req = 1'b0;
      repeat (1000) @(negedge clk_50m);
      vol_req = 1'b1;
      vol_val = 7'h60;
      @(negedge clk_50m);
      vol_req = 1'b0;
      wait_for(base + 12, 20000, "vol");
      chk("vol_count", log_n - base, 12);
      chk("vol_init_last", {16'd0, log_word[base + 10]}, 32'h1201);
      chk("vol_word", {16'd0, log_word[base + 11]}, 32'h05E0);
      chk("vol_ack_pulses", vack_n, 1);
      chk("vol_cfg_done", {31'd0, cfg_done}, 32'd1);

      // cfg_go and vol_req in the same IDLE cycle
      base = log_n;
      @(negedge clk_50m);
      cfg_go  = 1'b1;
      vol_req = 1'b1;
      vol_val = 7'h11;
      @(negedge clk_50m);
      cfg_go  = 1'b0;
      vol_req = 1'b0;
      wait_for(base + 12, 20000, "prio");
      chk("prio_first", {16'd0, log_word[base]}, 32'h1E00);
      chk("prio_count", log_n - base, 12);
      chk("prio_vol_after_init", {16'd0, log_word[base + 11]}, 32'h0591);
      chk("prio_vol_ack_pulses", vack_n, 2);

      // Async reset during WAIT of index 5
      base = log_n;
      pulse_go(g0);
      wait_log(base + 6, 10000);
      repeat (50) @(negedge clk_50m);
      rst_n = 1'b0;
      #1;
      chk("arst_busy",     {31'd0, busy},       32'd0);
      chk("arst_i2c_word", {16'd0, ifc.i2c_word}, 32'h0000);
      chk("arst_i2c_go",   {31'd0, ifc.i2c_go}, 32'd0);
      chk("arst_cfg_done", {31'd0, cfg_done},   32'd0);
      chk("arst_cfg_err",  {31'd0, cfg_err},    32'd0);
      repeat (5) @(negedge clk_50m);
      rst_n = 1'b1;
      repeat (150) @(negedge clk_50m);
      #2;
      chk("arst_no_go_after", log_n - base, 6);
      base = log_n;
      pulse_go(g0);
      wait_for(base + 11, 15000, "restart");
      chk("restart_first", {16'd0, log_word[base]}, 32'h1E00);
      chk("restart_count", log_n - base, 11);
      chk("restart_cfg_done", {31'd0, cfg_done}, 32'd1);

`ifdef CFG_TIMEOUT_EN
      // Writer silent: watchdog-driven retries then error
      no_resp = 1'b1;
      base = log_n;
      pulse_go(g0);
      wait_for(base + 4, 20000, "tmo");
      repeat (3000) @(negedge clk_50m);
      #2;
      chk("tmo_count", log_n - base, 4);
      chk("tmo_words", count_word(base, base + 4, 16'h1E00), 4);
      chk("tmo_spacing_ge_1000", {31'd0, min_gap(base, base + 4) >= 1000}, 32'd1);
      chk("tmo_cfg_err", {31'd0, cfg_err}, 32'd1);
      chk("tmo_cfg_done", {31'd0, cfg_done}, 32'd0);
      no_resp = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
